// File: rtl/tube_scroller_if.sv
// Tube scroller bus: control inputs from the game core and the three
// obstacle slots presented to the renderer and the score logic.
interface tube_scroller_if;
    logic             frame_tick;
    logic             run;
    logic             clear;
    logic [2:0][10:0] tube_x;
    logic [2:0][10:0] gap_y;
    logic             pass_pulse;
    logic [1:0]       active_cnt;

    modport master (
        output frame_tick, run, clear,
        input  tube_x, gap_y, pass_pulse, active_cnt
    );

    modport slave (
        input  frame_tick, run, clear,
        output tube_x, gap_y, pass_pulse, active_cnt
    );
endinterface

// File: rtl/tube_scroller.sv
// tube_scroller: three-slot tube obstacle generator. Scrolls tubes left on
// every frame tick while running, spawns new tubes at a fixed tick period
// with LFSR-derived gap heights, retires tubes leaving the screen and pulses
// pass_pulse when a tube clears the bird column.
// Optional build macro TUBE_SPEED_RAMP_EN: the scroll step grows by one
// pixel every 8th spawn, saturating at twice SPEED.
module tube_scroller #(
    parameter int unsigned SCREEN_W     = 1024,
    parameter int unsigned TUBE_WIDTH   = 120,
    parameter int unsigned SPEED        = 4,
    parameter int unsigned SPAWN_PERIOD = 90,
    parameter int unsigned GAP_MIN      = 100,
    parameter int unsigned GAP_RANGE    = 318,
    parameter int unsigned PASS_X       = 180,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst_n,
    tube_scroller_if.slave bus
);
    localparam logic [10:0]    PARKED    = 11'h7FF;
    localparam int unsigned    CW        = $clog2(SPAWN_PERIOD + 1);
    localparam logic [CW-1:0]  RELOAD    = CW'(SPAWN_PERIOD - 1);
    localparam logic [10:0]    SPAWN_X   = 11'(SCREEN_W);
    localparam logic [11:0]    TUBE_W12  = 12'(TUBE_WIDTH);
    localparam logic [11:0]    PASS_X12  = 12'(PASS_X);
    localparam logic [9:0]     RANGE10   = 10'(GAP_RANGE);
    localparam logic [10:0]    GAP_MIN11 = 11'(GAP_MIN);
    localparam logic [10:0]    SPEED11   = 11'(SPEED);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FROZEN = 2'd2
    } state_t;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    // Fold the 9 low LFSR bits into the legal gap range and offset it.
    function automatic logic [10:0] gap_from_lfsr(input logic [8:0] l);
        logic [9:0] raw;
        logic [9:0] r;
        raw = {1'b0, l};
        if (raw < RANGE10) begin
            r = raw;
        end else begin
            r = raw - RANGE10;
        end
        return GAP_MIN11 + {1'b0, r};
    endfunction

    state_t           state_q, state_d;
    logic [2:0][10:0] tube_x_q, tube_x_d;
    logic [2:0][10:0] gap_y_q, gap_y_d;
    logic             pass_q, pass_d;
    logic [1:0]       active_cnt_q, active_cnt_d;
    logic [CW-1:0]    spawn_cnt_q, spawn_cnt_d;
    logic [15:0]      lfsr_q;
    logic [2:0][10:0] new_x_s;
    logic             spawn_ok_s;
    logic [1:0]       spawn_idx_s;
    logic [10:0]      speed_s;

`ifdef TUBE_SPEED_RAMP_EN
    localparam logic [10:0] SPEED_MAX = 11'(2 * SPEED);
    logic [10:0] speed_q, speed_d;
    logic [2:0]  spawn_n_q, spawn_n_d;
    assign speed_s = speed_q;
`else
    assign speed_s = SPEED11;
`endif

    // Next state: FSM transitions, scrolling, pass detection, spawning, slot count
    always_comb begin
        state_d      = state_q;
        tube_x_d     = tube_x_q;
        gap_y_d      = gap_y_q;
        pass_d       = 1'b0;
        spawn_cnt_d  = spawn_cnt_q;
        spawn_ok_s   = 1'b0;
        spawn_idx_s  = 2'd0;
        active_cnt_d = 2'd0;
`ifdef TUBE_SPEED_RAMP_EN
        speed_d      = speed_q;
        spawn_n_d    = spawn_n_q;
`endif
        for (int i = 0; i < 3; i++) begin
            new_x_s[i] = tube_x_q[i] - speed_s;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_d     = S_RUN;
                    spawn_cnt_d = '0;
                end else begin
                    state_d     = S_IDLE;
                end
            end
            S_RUN: begin
                if (bus.frame_tick) begin
                    // Scroll active slots; a slot retiring this tick cannot fire a pass.
                    for (int i = 0; i < 3; i++) begin
                        if (tube_x_q[i] == PARKED) begin
                            tube_x_d[i] = PARKED;
                        end else if (tube_x_q[i] < speed_s) begin
                            tube_x_d[i] = PARKED;
                        end else begin
                            tube_x_d[i] = new_x_s[i];
                            if ((({1'b0, tube_x_q[i]} + TUBE_W12) >= PASS_X12) &&
                                (({1'b0, new_x_s[i]} + TUBE_W12) < PASS_X12)) begin
                                pass_d = 1'b1;
                            end else begin
                                pass_d = pass_d;
                            end
                        end
                    end
                    if (spawn_cnt_q == '0) begin
                        // Descending scan leaves the lowest free slot selected.
                        for (int i = 2; i >= 0; i--) begin
                            if (tube_x_d[i] == PARKED) begin
                                spawn_ok_s  = 1'b1;
                                spawn_idx_s = 2'(i);
                            end else begin
                                spawn_ok_s  = spawn_ok_s;
                            end
                        end
                        if (spawn_ok_s) begin
                            for (int i = 0; i < 3; i++) begin
                                if (spawn_idx_s == 2'(i)) begin
                                    tube_x_d[i] = SPAWN_X;
                                    gap_y_d[i]  = gap_from_lfsr(lfsr_q[8:0]);
                                end else begin
                                    gap_y_d[i]  = gap_y_d[i];
                                end
                            end
                            spawn_cnt_d = RELOAD;
`ifdef TUBE_SPEED_RAMP_EN
                            spawn_n_d = spawn_n_q + 3'd1;
                            if ((spawn_n_q == 3'd7) && (speed_q < SPEED_MAX)) begin
                                speed_d = speed_q + 11'd1;
                            end else begin
                                speed_d = speed_q;
                            end
`endif
                        end else begin
                            // All slots busy: hold at zero and retry next tick.
                            spawn_cnt_d = '0;
                        end
                    end else begin
                        spawn_cnt_d = spawn_cnt_q - CW'(1);
                    end
                end else begin
                    tube_x_d = tube_x_q;
                end
                if (bus.run) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_FROZEN;
                end
            end
            S_FROZEN: begin
                if (bus.run) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_FROZEN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // clear overrides run and frame_tick.
        if (bus.clear) begin
            state_d     = S_IDLE;
            tube_x_d    = {3{PARKED}};
            spawn_cnt_d = '0;
            pass_d      = 1'b0;
`ifdef TUBE_SPEED_RAMP_EN
            speed_d     = SPEED11;
            spawn_n_d   = 3'd0;
`endif
        end else begin
            state_d     = state_d;
        end

        for (int i = 0; i < 3; i++) begin
            if (tube_x_d[i] != PARKED) begin
                active_cnt_d = active_cnt_d + 2'd1;
            end else begin
                active_cnt_d = active_cnt_d;
            end
        end
    end

    // FSM, slot, pulse and spawn counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tube_x_q     <= {3{PARKED}};
            gap_y_q      <= '0;
            pass_q       <= 1'b0;
            active_cnt_q <= 2'd0;
            spawn_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            tube_x_q     <= tube_x_d;
            gap_y_q      <= gap_y_d;
            pass_q       <= pass_d;
            active_cnt_q <= active_cnt_d;
            spawn_cnt_q  <= spawn_cnt_d;
        end
    end

    // Free-running gap generator, advances every cycle in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

`ifdef TUBE_SPEED_RAMP_EN
    // Effective scroll speed and spawn tally for the ramp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_q   <= SPEED11;
            spawn_n_q <= 3'd0;
        end else begin
            speed_q   <= speed_d;
            spawn_n_q <= spawn_n_d;
        end
    end
`endif

    assign bus.tube_x     = tube_x_q;
    assign bus.gap_y      = gap_y_q;
    assign bus.pass_pulse = pass_q;
    assign bus.active_cnt = active_cnt_q;
endmodule

// File: tb/tb_tube_scroller.sv
// Scoreboard bench for tube_scroller. Stimulus pushes the expected slot state
// for every frame tick, clear and reset; a monitor pops and compares whenever
// the DUT responds. The spawn period is shortened to 80 ticks so all three
// slots fill before the oldest tube retires (lifetime 257 ticks).
module tb_tube_scroller;
    localparam int          TB_PERIOD = 80;
    localparam logic [10:0] PARKED    = 11'h7FF;

    logic clk;
    logic rst_n;

    tube_scroller_if bus();

    tube_scroller #(.SPAWN_PERIOD(TB_PERIOD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // gmode: 0 = ignore gaps, 1 = gaps of drawn slots, 2 = all gaps
    typedef struct packed {
        logic [2:0][10:0] x;
        logic [2:0][10:0] g;
        logic [1:0]       gmode;
        logic             pass;
        logic [1:0]       cnt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    n_pass_seen = 0;

    // Reference model state
    logic [15:0]      m_lfsr;
    logic [2:0][10:0] m_x;
    logic [2:0][10:0] m_g;
    int               m_cnt;
    int               m_spd;
    int               m_spawns;
    int               m_pass_exp;
    int               m_state;   // 0 idle, 1 run, 2 frozen

    // Model LFSR: right-shift Fibonacci with taps 16,14,13,11
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else m_lfsr <= (m_lfsr >> 1) |
                       (16'((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'd1) << 15);
    end

    function automatic logic [10:0] model_gap(input logic [15:0] l);
        int r;
        r = int'(l[8:0]);
        if (r >= 318) r = r - 318;
        return 11'(100 + r);
    endfunction

    task automatic push_exp(input string tag, input logic [1:0] gmode, input logic p);
        exp_t e;
        int   c;
        c = 0;
        for (int i = 0; i < 3; i++) if (m_x[i] != PARKED) c++;
        e.x = m_x; e.g = m_g; e.gmode = gmode; e.pass = p; e.cnt = 2'(c);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_one();
        exp_t  e;
        string t;
        logic  bad;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL no_expectation: DUT responded with empty scoreboard at %0t", $time);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        bad = (bus.tube_x !== e.x) || (bus.pass_pulse !== e.pass) || (bus.active_cnt !== e.cnt);
        for (int i = 0; i < 3; i++) begin
            if ((e.gmode == 2'd2 || (e.gmode == 2'd1 && e.x[i] != PARKED)) && bus.gap_y[i] !== e.g[i])
                bad = 1'b1;
        end
        if (bad) begin
            n_fail++;
            $display("FAIL %s @%0t: got x=%0d/%0d/%0d g=%0d/%0d/%0d pass=%b cnt=%0d, want x=%0d/%0d/%0d g=%0d/%0d/%0d pass=%b cnt=%0d",
                     t, $time, bus.tube_x[0], bus.tube_x[1], bus.tube_x[2],
                     bus.gap_y[0], bus.gap_y[1], bus.gap_y[2], bus.pass_pulse, bus.active_cnt,
                     e.x[0], e.x[1], e.x[2], e.g[0], e.g[1], e.g[2], e.pass, e.cnt);
        end
    endtask

    // Monitor: reset response, checked right after rst_n falls
    always @(negedge rst_n) begin
        #1;
        check_one();
    end

    // Monitor: response to a frame tick or clear, visible after the edge
    always @(posedge clk) begin
        if (rst_n === 1'b1 && (bus.frame_tick === 1'b1 || bus.clear === 1'b1)) begin
            #1;
            check_one();
        end
    end

    // Monitor: count every cycle pass_pulse is high
    always @(posedge clk) begin
        #1;
        if (bus.pass_pulse === 1'b1) n_pass_seen++;
    end

    task automatic model_reset();
        m_x = {3{PARKED}}; m_g = '0; m_cnt = 0; m_spd = 4; m_spawns = 0; m_state = 0;
    endtask

    task automatic apply_reset(input string tag);
        model_reset();
        push_exp(tag, 2'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        bus.run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_run(input logic v);
        bus.run = v;
        @(negedge clk);
        if (v) m_state = 1;
        else if (m_state == 1) m_state = 2;
    endtask

    task automatic do_tick(input string tag);
        logic [15:0] l;
        logic        p;
        int          ox, nx, idx;
        l = m_lfsr;
        p = 1'b0;
        if (m_state == 1) begin
            for (int i = 0; i < 3; i++) begin
                if (m_x[i] != PARKED) begin
                    ox = int'(m_x[i]);
                    if (ox < m_spd) m_x[i] = PARKED;
                    else begin
                        nx = ox - m_spd;
                        if (ox + 120 >= 180 && nx + 120 < 180) p = 1'b1;
                        m_x[i] = 11'(nx);
                    end
                end
            end
            if (m_cnt == 0) begin
                idx = -1;
                for (int i = 2; i >= 0; i--) if (m_x[i] == PARKED) idx = i;
                if (idx >= 0) begin
                    m_x[idx] = 11'd1024;
                    m_g[idx] = model_gap(l);
                    m_cnt = TB_PERIOD - 1;
                    m_spawns++;
`ifdef TUBE_SPEED_RAMP_EN
                    if (m_spawns % 8 == 0 && m_spd < 8) m_spd++;
`endif
                end
            end else begin
                m_cnt--;
            end
        end
        if (p) m_pass_exp++;
        push_exp(tag, 2'd1, p);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic cmp_int(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.run        = 1'b0;
        bus.clear      = 1'b0;
        rst_n          = 1'b1;
        m_pass_exp     = 0;
        model_reset();
        @(negedge clk);
        apply_reset("reset_initial");

        do_tick("idle_tick_ignored");
        set_run(1'b1);
        do_tick("first_spawn");
        repeat (TB_PERIOD) do_tick("scroll_to_second_spawn");
        repeat (180) do_tick("pass_block_retire");

        set_run(1'b0);
        repeat (10) do_tick("frozen_hold");
        set_run(1'b1);
        repeat (TB_PERIOD) do_tick("resume_held_counter");

        // clear together with run and frame_tick
        bus.clear      = 1'b1;
        bus.frame_tick = 1'b1;
        m_x = {3{PARKED}}; m_cnt = 0; m_spd = 4; m_spawns = 0; m_state = 0;
        push_exp("clear_with_run_and_tick", 2'd0, 1'b0);
        @(negedge clk);
        bus.clear      = 1'b0;
        bus.frame_tick = 1'b0;
        @(negedge clk);
        m_state = 1;
        do_tick("spawn_after_clear");
        repeat (20) do_tick("run_before_reset");

        apply_reset("reset_mid_run");
        set_run(1'b1);
        repeat (700) do_tick("long_run");

        cmp_int("pass_pulse_cycles", n_pass_seen, m_pass_exp);
        cmp_int("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
